// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ITERATIONS = 32;
  localparam int unsigned CNT_W      = $clog2(ITERATIONS);

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [WIDTH-1:0] SIGN_MIN      = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div_op(input op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand conditioning: magnitudes, result-negate flag and special-case detection.
module muldiv_operand_prep
  import muldiv_pkg::*;
(
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_mag_c,
  output logic [WIDTH-1:0] b_mag_c,
  output logic             negate_c,
  output logic             div_zero_c,
  output logic             overflow_c,
  output logic             mul_zero_c,
  output logic [WIDTH-1:0] special_c
);

  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;
  logic is_div;
  logic is_rem;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign is_div = is_div_op(op);
  assign is_rem = op[2] & op[1];
  assign a_neg  = a_signed & a[WIDTH-1];
  assign b_neg  = b_signed & b[WIDTH-1];

  assign a_mag_c = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag_c = b_neg ? (~b + WIDTH'(1)) : b;

  // Remainder follows the dividend sign; products and quotients follow the sign XOR
  assign negate_c = a_neg ^ (is_rem ? 1'b0 : b_neg);

  assign div_zero_c = is_div && (b == '0);
  assign overflow_c = is_div && a_signed && (a == SIGN_MIN) && (b == '1);
  assign mul_zero_c = !is_div && ((a == '0) || (b == '0));

  always_comb begin
    special_c = '0;
    if (div_zero_c) begin
      special_c = is_rem ? a : DIV0_QUOTIENT;
    end else if (overflow_c) begin
      special_c = is_rem ? '0 : SIGN_MIN;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with register-file write-back outputs.
// Optional MULDIV_FAST_EN: special cases skip CALC and complete one cycle after start.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [4:0]       rd_addr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             we
);

  state_e state_q, state_d;

  op_e              op_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, special_c;
  logic             negate_c, div_zero_c, overflow_c, mul_zero_c;
  logic             override_c, bypass_c;

  op_e              op_q;
  logic [4:0]       rd_q;
  logic             neg_q;
  logic             ovr_q;
  logic [WIDTH-1:0] ovr_val_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]     add_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   hi_nx, lo_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, calc_res;

  logic             busy_d, done_d, we_d;
  logic [WIDTH-1:0] result_d;
  logic [4:0]       rd_out_d;

  assign op_c = op_e'(funct3);

  muldiv_operand_prep u_prep (
    .op         (op_c),
    .a          (rs1_val),
    .b          (rs2_val),
    .a_mag_c    (a_mag_c),
    .b_mag_c    (b_mag_c),
    .negate_c   (negate_c),
    .div_zero_c (div_zero_c),
    .overflow_c (overflow_c),
    .mul_zero_c (mul_zero_c),
    .special_c  (special_c)
  );

  // Special cases all have a fixed answer; the iteration result is discarded for them
  assign override_c = div_zero_c | overflow_c | mul_zero_c;

`ifdef MULDIV_FAST_EN
  assign bypass_c = override_c;
`else
  assign bypass_c = 1'b0;
`endif

  // One shift-add or restoring-divide step on the shared {hi, lo} register pair
  always_comb begin
    add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (is_div_op(op_q)) begin
      if (div_diff[WIDTH]) begin
        hi_nx = div_shift[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_nx = div_diff[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      {hi_nx, lo_nx} = {add_sum, lo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up and field select on the post-final-step values
  always_comb begin
    prod = neg_q ? (~{hi_nx, lo_nx} + (2*WIDTH)'(1)) : {hi_nx, lo_nx};
    quo  = neg_q ? (~lo_nx + WIDTH'(1)) : lo_nx;
    rem  = neg_q ? (~hi_nx + WIDTH'(1)) : hi_nx;
    case (op_q)
      OP_MUL:                       calc_res = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              calc_res = quo;
      default:                      calc_res = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy;
    done_d   = 1'b0;
    we_d     = 1'b0;
    result_d = result;
    rd_out_d = rd_out;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (bypass_c) begin
            state_d  = DONE;
            done_d   = 1'b1;
            we_d     = (rd_addr != '0);
            result_d = special_c;
            rd_out_d = rd_addr;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
          state_d  = DONE;
          done_d   = 1'b1;
          we_d     = (rd_q != '0);
          result_d = ovr_q ? ovr_val_q : calc_res;
          rd_out_d = rd_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      we      <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      we      <= we_d;
      result  <= result_d;
      rd_out  <= rd_out_d;
    end
  end

  // Operand latch at issue, then one iteration per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_MUL;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_val_q <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
    end else if (state_q == IDLE && start) begin
      op_q      <= op_c;
      rd_q      <= rd_addr;
      neg_q     <= negate_c;
      ovr_q     <= override_c;
      ovr_val_q <= special_c;
      b_q       <= b_mag_c;
      hi_q      <= '0;
      lo_q      <= a_mag_c;
      cnt_q     <= '0;
    end else if (state_q == CALC) begin
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
